// File: rtl/frogger_life_manager_pkg.sv
// Shared types and defaults for the frogger game-state sequencer.
// Covers lives, score, death freeze, respawn and game over.
package frogger_life_manager_pkg;

    localparam int LIVES_W = 3;
    localparam int SCORE_W = 7;
    localparam int Y_W     = 6;

    localparam int START_LIVES  = 3;
    localparam int DEATH_FRAMES = 30;
    localparam int GRACE_FRAMES = 4;
    localparam int GOAL_Y       = 0;
    localparam int SCORE_MAX    = 99;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESPAWN,
        S_PLAY,
        S_DYING,
        S_GAME_OVER
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v,
        input logic [SCORE_W-1:0] max
    );
        return (v >= max) ? max : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/frogger_life_manager_if.sv
// Game-control bundle between the sequencer, collision
// logic, frog position block and the status display.
interface frogger_life_manager_if;
    import frogger_life_manager_pkg::*;

    logic               frame_tick;
    logic               start;
    logic               collided;
    logic [Y_W-1:0]     frogger_y;
    logic               freeze;
    logic               respawn;
    logic               dying;
    logic               game_over;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;

    modport master (
        output frame_tick, start, collided, frogger_y,
        input  freeze, respawn, dying, game_over, lives, score
    );

    modport slave (
        input  frame_tick, start, collided, frogger_y,
        output freeze, respawn, dying, game_over, lives, score
    );

endinterface

// File: rtl/frogger_life_manager_frame_countdown.sv
// Loadable frame countdown: load wins over tick, stops at zero.
// Used as the death timer and the post-respawn grace timer.
module frame_countdown #(
    parameter int N = 30,
    localparam int W = $clog2(N + 1)
) (
    input  logic         i_Clk,
    input  logic         i_Rst_L,
    input  logic         load,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         zero
);

    assign zero = (count == '0);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count <= '0;
        end else if (load) begin
            count <= W'(N);
        end else if (tick && !zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/frogger_life_manager.sv
// Frogger game-state sequencer: lives, score, death freeze,
// respawn pulse and game over, all outputs registered.
module frogger_life_manager
    import frogger_life_manager_pkg::*;
#(
    parameter int c_START_LIVES  = START_LIVES,
    parameter int c_DEATH_FRAMES = DEATH_FRAMES,
    parameter int c_GRACE_FRAMES = GRACE_FRAMES,
    parameter int c_GOAL_Y       = GOAL_Y,
    parameter int c_SCORE_MAX    = SCORE_MAX
) (
    input logic                   i_Clk,
    input logic                   i_Rst_L,
    frogger_life_manager_if.slave bus
);

    localparam int DW = $clog2(c_DEATH_FRAMES + 1);
    localparam int GW = $clog2(c_GRACE_FRAMES + 1);

    state_t             state;
    state_t             state_d;
    logic               start_q;
    logic               start_edge;
    logic [LIVES_W-1:0] lives_d;
    logic [SCORE_W-1:0] score_d;
    logic               death_load;
    logic               grace_load;
    logic [DW-1:0]      death_cnt;
    logic               death_zero;
    logic [GW-1:0]      grace_cnt;
    logic               grace_zero;
    logic               unused_cnt;

    assign start_edge = bus.start & ~start_q;
    assign unused_cnt = ^{death_zero, grace_cnt};

    frame_countdown #(.N(c_DEATH_FRAMES)) u_death (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .load    (death_load),
        .tick    (bus.frame_tick && state == S_DYING),
        .count   (death_cnt),
        .zero    (death_zero)
    );

    frame_countdown #(.N(c_GRACE_FRAMES)) u_grace (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .load    (grace_load),
        .tick    (bus.frame_tick && state == S_PLAY),
        .count   (grace_cnt),
        .zero    (grace_zero)
    );

    always_comb begin
        state_d    = state;
        lives_d    = bus.lives;
        score_d    = bus.score;
        death_load = 1'b0;
        grace_load = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_edge) state_d = S_RESPAWN;
            end
            S_RESPAWN: begin
                grace_load = 1'b1;
                state_d    = S_PLAY;
            end
            S_PLAY: begin
                // Collision outranks a goal landed on the same cycle
                if (grace_zero && bus.collided) begin
                    lives_d    = (bus.lives == '0) ? '0
                               : bus.lives - LIVES_W'(1);
                    death_load = 1'b1;
                    state_d    = S_DYING;
                end else if (grace_zero &&
                             bus.frogger_y == Y_W'(c_GOAL_Y)) begin
                    score_d = sat_inc(bus.score,
                                      SCORE_W'(c_SCORE_MAX));
                    state_d = S_RESPAWN;
                end
            end
            S_DYING: begin
                if (bus.frame_tick && death_cnt == DW'(1)) begin
                    state_d = (bus.lives == '0) ? S_GAME_OVER
                                                : S_RESPAWN;
                end
            end
            S_GAME_OVER: begin
                if (start_edge) begin
                    lives_d = LIVES_W'(c_START_LIVES);
                    score_d = '0;
                    state_d = S_RESPAWN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state         <= S_IDLE;
            start_q       <= 1'b0;
            bus.freeze    <= 1'b1;
            bus.respawn   <= 1'b0;
            bus.dying     <= 1'b0;
            bus.game_over <= 1'b0;
            bus.lives     <= LIVES_W'(c_START_LIVES);
            bus.score     <= '0;
        end else begin
            state         <= state_d;
            start_q       <= bus.start;
            bus.freeze    <= (state_d != S_PLAY);
            bus.respawn   <= (state_d == S_RESPAWN);
            bus.dying     <= (state_d == S_DYING);
            bus.game_over <= (state_d == S_GAME_OVER);
            bus.lives     <= lives_d;
            bus.score     <= score_d;
        end
    end

endmodule

// File: tb/tb_frogger_life_manager.sv
// Scoreboard bench for frogger_life_manager: a game-rule model
// queues expected outputs, a monitor compares every cycle.
module tb_frogger_life_manager;

    localparam int START = 3;
    localparam int DEATH = 30;
    localparam int GRACE = 4;
    localparam int GOAL  = 0;
    localparam int SMAX  = 99;

    localparam int P_IDLE  = 0;
    localparam int P_RESP  = 1;
    localparam int P_PLAY  = 2;
    localparam int P_DYING = 3;
    localparam int P_OVER  = 4;

    typedef struct {
        bit freeze;
        bit respawn;
        bit dying;
        bit over;
        int lives;
        int score;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    frogger_life_manager_if bus();

    frogger_life_manager dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    int m_phase;
    int m_grace;
    int m_death;
    int m_lives;
    int m_score;
    bit m_prev;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_grace = 0;
        m_death = 0;
        m_lives = START;
        m_score = 0;
        m_prev  = 1'b0;
    endtask

    // Game rules applied once per clock edge
    task automatic model_step(input bit t, input bit s,
                              input bit c, input int y);
        bit pressed;
        pressed = s && !m_prev;
        m_prev = s;
        case (m_phase)
            P_IDLE: if (pressed) m_phase = P_RESP;
            P_RESP: begin
                m_grace = GRACE;
                m_phase = P_PLAY;
            end
            P_PLAY: begin
                if (m_grace > 0) begin
                    if (t) m_grace--;
                end else if (c) begin
                    if (m_lives > 0) m_lives--;
                    m_death = DEATH;
                    m_phase = P_DYING;
                end else if (y == GOAL) begin
                    if (m_score < SMAX) m_score++;
                    m_phase = P_RESP;
                end
            end
            P_DYING: begin
                if (t) begin
                    m_death--;
                    if (m_death == 0)
                        m_phase = (m_lives == 0) ? P_OVER : P_RESP;
                end
            end
            P_OVER: begin
                if (pressed) begin
                    m_lives = START;
                    m_score = 0;
                    m_phase = P_RESP;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic cyc(input bit t, input bit s,
                       input bit c, input int y);
        exp_t e;
        @(negedge clk);
        bus.frame_tick = t;
        bus.start      = s;
        bus.collided   = c;
        bus.frogger_y  = 6'(y);
        model_step(t, s, c, y);
        e.freeze  = (m_phase != P_PLAY);
        e.respawn = (m_phase == P_RESP);
        e.dying   = (m_phase == P_DYING);
        e.over    = (m_phase == P_OVER);
        e.lives   = m_lives;
        e.score   = m_score;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_freeze"},  32'(bus.freeze),    32'd1);
        chk({tag, "_respawn"}, 32'(bus.respawn),   32'd0);
        chk({tag, "_dying"},   32'(bus.dying),     32'd0);
        chk({tag, "_over"},    32'(bus.game_over), 32'd0);
        chk({tag, "_lives"},   32'(bus.lives),     32'(START));
        chk({tag, "_score"},   32'(bus.score),     32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.collided   = 1'b0;
        bus.frogger_y  = 6'd5;
        rst_n = 1'b0;
        #1;
        check_reset_values(tag);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_open(input int y);
        for (int k = 0; k < 200; k++) begin
            if (m_phase == P_PLAY && m_grace == 0) break;
            cyc(1'b1, 1'b0, 1'b0, y);
        end
    endtask

    task automatic run_until_not_dying(input bit s);
        for (int k = 0; k < 200; k++) begin
            if (m_phase != P_DYING) break;
            cyc(1'b1, s, 1'b1, 7);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("freeze",    32'(bus.freeze),    32'(e.freeze));
            chk("respawn",   32'(bus.respawn),   32'(e.respawn));
            chk("dying",     32'(bus.dying),     32'(e.dying));
            chk("game_over", 32'(bus.game_over), 32'(e.over));
            chk("lives",     32'(bus.lives),     32'(e.lives));
            chk("score",     32'(bus.score),     32'(e.score));
        end
    end

    initial begin
        bit s_lvl;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.collided   = 1'b0;
        bus.frogger_y  = 6'd5;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, then a held start gives exactly one respawn
        cyc(1'b1, 1'b0, 1'b0, 5);
        cyc(1'b1, 1'b0, 1'b1, 0);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 5);

        // Early collision and goal ignored during grace
        cyc(1'b1, 1'b0, 1'b1, 5);
        cyc(1'b0, 1'b0, 1'b1, 0);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 5);
        cyc(1'b0, 1'b0, 1'b1, 5);
        run_until_not_dying(1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 5);

        // Goals until score saturates, then a few more
        for (int k = 0; k < 2000 && m_score < SMAX; k++)
            cyc(1'b1, 1'b0, 1'b0, GOAL);
        repeat (14) cyc(1'b1, 1'b0, 1'b0, GOAL);

        // Collision and goal together
        run_until_open(7);
        cyc(1'b0, 1'b0, 1'b1, GOAL);
        run_until_not_dying(1'b0);

        // Third death with start held through game over
        run_until_open(7);
        cyc(1'b0, 1'b1, 1'b1, 7);
        run_until_not_dying(1'b1);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 7);
        cyc(1'b0, 1'b0, 1'b0, 7);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 7);
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 7);

        // Reset in the middle of a death freeze
        run_until_open(7);
        cyc(1'b0, 1'b0, 1'b1, 7);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 7);
        do_reset("mid_dying");
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 7);

        s_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset("mid_random");
            if ($urandom_range(14) == 0) s_lvl = ~s_lvl;
            cyc(($urandom_range(2) == 0), s_lvl,
                ($urandom_range(11) == 0), int'($urandom_range(5)));
        end

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
